mem_bus_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between two masters of the cpu_riscv core:
  - the instruction-fetch stage (master IF);
  - the load/store stage (master DM).
- Sits inside cpu_riscv_min_sopc, between the core and the memory.
- Sequences one memory transaction at a time using a req/ack handshake on each master and a ce/ready handshake on the memory side.
- Exports a stall request to the pipeline control logic.

---
 rtl/mem_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-port instruction/data memory of
// cpu_riscv_min_sopc between the fetch stage (IF) and the load/store stage
// (DM). One memory transaction runs at a time; IDLE grants are registered.
// DM wins by default, but IF is forced in after STARVE_MAX consecutive DM
// grants taken while IF was waiting.
// Optional build macro ARB_TIMEOUT_EN adds a memory-ready watchdog that
// abandons a stuck transaction after TIMEOUT busy cycles and pulses bus_err.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch master
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // load/store master
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  // memory side
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // pipeline control
  output logic              stall_req,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       grant_dm;
  logic       grant_if;
  logic       busy_done;
  logic       wd_expire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, leave BUSY on ready or watchdog expiry
  always_comb begin
    grant_dm  = dm_req && (!if_req || (starve_cnt < STARVE_LIM));
    grant_if  = if_req && !grant_dm;
    busy_done = mem_ready || wd_expire;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nxt = DM_BUSY;
        end else if (grant_if) begin
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (busy_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: strobe follows ownership, stall while any request is unanswered
  always_comb begin
    mem_ce    = (state != IDLE);
    stall_req = (if_req && !if_ack) || (dm_req && !dm_ack);
  end

  // Datapath: latch the granted request, count DM-over-IF grants, return read data
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_sel    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            mem_we    <= dm_we;
            mem_sel   <= dm_sel;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && (starve_cnt != 4'hF)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_if) begin
            mem_we     <= 1'b0;
            mem_sel    <= '1;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end else if (wd_expire) begin
            if_ack   <= 1'b1;
            if_rdata <= '0;
          end
        end
        DM_BUSY: begin
          if (mem_ready) begin
            dm_ack   <= 1'b1;
            dm_rdata <= mem_we ? '0 : mem_rdata;
          end else if (wd_expire) begin
            dm_ack   <= 1'b1;
            dm_rdata <= '0;
          end
        end
        default: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;

  // Expiry fires on the TIMEOUT-th busy cycle when ready is still low
  assign wd_expire = (state != IDLE) && !mem_ready && (wd_cnt == WD_LAST);

  // Watchdog: held at zero in IDLE, counts busy cycles, flags the abandon cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
        if (wd_expire) begin
          bus_err <= 1'b1;
        end
      end
    end
  end
`else
  // No watchdog: a busy state waits for mem_ready indefinitely.
  assign wd_expire = 1'b0;
  assign bus_err   = 1'b0 & (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of single-master transactions
// plus hand-written contention, reset-abort and (with ARB_TIMEOUT_EN) watchdog
// sequences. The memory is modelled with a configurable number of wait states.
module tb_mem_bus_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_sel = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_req;
  logic        bus_err;

  mem_bus_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_sel   (dm_sel),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_req(stall_req),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_val;
    int          wait_n;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_n   = 0;
  int          ce_cycles = 0;
  logic [31:0] rd_val   = '0;
  logic [31:0] last_if_rdata = '0;
  logic [31:0] last_dm_rdata = '0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; afterwards the memory model answers with wait_n wait states.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_ce) begin
      mem_ready = (ce_cycles >= wait_n);
      ce_cycles++;
    end else begin
      mem_ready = 1'b0;
      ce_cycles = 0;
    end
    mem_rdata = mem_ready ? rd_val : 32'hBADB_AD00;
    if (if_ack && dm_ack) begin
      check1("ack_exclusive", 1'b1, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    cycles;
    int    ce_cnt;
    bit    got;
    bit    stable_ok;
    bit    stall_ok;
    string tag;
    cycles = 0; ce_cnt = 0; got = 0; stable_ok = 1; stall_ok = 1;
    tag    = $sformatf("v%0d", idx);
    wait_n = v.wait_n;
    rd_val = v.rd_val;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_sel = v.sel; dm_addr = v.addr; dm_wdata = v.wdata;
      if_req = 1'b0; if_addr = 32'h7777_0000;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      dm_req = 1'b0; dm_we = 1'b1; dm_sel = 4'hA; dm_addr = 32'h5555_0000; dm_wdata = 32'h1111_2222;
    end
    while (!got && cycles < 200) begin
      tick();
      cycles++;
      if (mem_ce) begin
        ce_cnt++;
        if (ce_cnt == 1) begin
          check32({tag, "_mem_addr"}, mem_addr, v.exp_addr);
          check1({tag, "_mem_we"}, mem_we, v.exp_we);
          check32({tag, "_mem_sel"}, {28'h0, mem_sel}, {28'h0, v.exp_sel});
          check32({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
        end else if (mem_addr !== v.exp_addr || mem_we !== v.exp_we ||
                     mem_sel !== v.exp_sel || mem_wdata !== v.exp_wdata) begin
          stable_ok = 0;
        end
        if (stall_req !== 1'b1) stall_ok = 0;
      end
      if (if_ack || dm_ack) got = 1;
    end
    check1({tag, "_ack_seen"}, got, 1'b1);
    check_int({tag, "_latency"}, cycles, v.wait_n + 2);
    check_int({tag, "_ce_cycles"}, ce_cnt, v.wait_n + 1);
    check1({tag, "_mem_stable"}, stable_ok, 1'b1);
    check1({tag, "_stall_busy"}, stall_ok, 1'b1);
    check1({tag, "_if_ack"}, if_ack, !v.is_dm);
    check1({tag, "_dm_ack"}, dm_ack, v.is_dm);
    check1({tag, "_stall_ack"}, stall_req, 1'b0);
    check1({tag, "_ce_ack"}, mem_ce, 1'b0);
    check1({tag, "_bus_err"}, bus_err, 1'b0);
    if (v.is_dm) begin
      check32({tag, "_dm_rdata"}, dm_rdata, v.exp_rdata);
      check32({tag, "_if_rdata_hold"}, if_rdata, last_if_rdata);
      last_dm_rdata = v.exp_rdata;
    end else begin
      check32({tag, "_if_rdata"}, if_rdata, v.exp_rdata);
      check32({tag, "_dm_rdata_hold"}, dm_rdata, last_dm_rdata);
      last_if_rdata = v.exp_rdata;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    check1({tag, "_single_if_ack"}, if_ack, 1'b0);
    check1({tag, "_single_dm_ack"}, dm_ack, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t post_rst;
    logic exp_if [10];
    int   cyc;
    int   ce_cnt;
    bit   got;
    bit   seen_ack;
    logic [31:0] granted_addr;

    //          is_dm we  sel    addr           wdata          rd_val         wait exp_addr      we  sel    exp_wdata      exp_rdata
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'h0050_0093, 0, 32'h0000_0010, 1'b0, 4'hF, 32'h0,        32'h0050_0093};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 2, 32'h0000_0100, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'hCAFE_F00D, 32'hA5A5_5A5A, 0, 32'h0000_0200, 1'b0, 4'hF, 32'hCAFE_F00D, 32'hA5A5_5A5A};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0014, 32'h0,        32'h0010_0113, 3, 32'h0000_0014, 1'b0, 4'hF, 32'h0,        32'h0010_0113};
    vecs[4] = '{1'b1, 1'b0, 4'h4, 32'h0000_03FC, 32'h0,        32'h0000_FF00, 1, 32'h0000_03FC, 1'b0, 4'h4, 32'h0,        32'h0000_FF00};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,        32'hFFFF_FFFF};
    post_rst = '{1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'h0020_0193, 1, 32'h0000_0020, 1'b0, 4'hF, 32'h0,        32'h0020_0193};
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check1("rst_mem_ce", mem_ce, 1'b0);
    check1("rst_if_ack", if_ack, 1'b0);
    check1("rst_dm_ack", dm_ack, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_dm_rdata", dm_rdata, 32'h0);
    check1("rst_stall", stall_req, 1'b0);
    check1("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;
    tick();

    // Single-master transactions
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Contention: both requests held, DM x STARVE_MAX then IF, repeating
    if_req = 1'b1; if_addr = 32'h0000_0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0080; dm_wdata = 32'h0;
    wait_n = 0; rd_val = 32'h0BAD_F00D;
    for (int k = 0; k < 10; k++) begin
      cyc = 0; got = 0; granted_addr = '0;
      while (!got && cyc < 20) begin
        tick();
        cyc++;
        if (mem_ce) granted_addr = mem_addr;
        if (if_ack || dm_ack) got = 1;
      end
      check1($sformatf("contend%0d_if_ack", k), if_ack, exp_if[k]);
      check1($sformatf("contend%0d_dm_ack", k), dm_ack, !exp_if[k]);
      check32($sformatf("contend%0d_addr", k), granted_addr,
              exp_if[k] ? 32'h0000_0040 : 32'h0000_0080);
      check1($sformatf("contend%0d_stall", k), stall_req, 1'b1);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    last_if_rdata = 32'h0BAD_F00D;
    last_dm_rdata = 32'h0BAD_F00D;

    // Reset in the middle of a DM transaction
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'hF; dm_addr = 32'h0000_0240; dm_wdata = 32'h600D_0000;
    wait_n = 50; rd_val = 32'h0;
    cyc = 0;
    while (!mem_ce && cyc < 10) begin
      tick();
      cyc++;
    end
    check1("midrst_ce_before", mem_ce, 1'b1);
    tick(); tick();
    rst = 1'b1; dm_req = 1'b0;
    tick();
    check1("midrst_mem_ce", mem_ce, 1'b0);
    check1("midrst_dm_ack", dm_ack, 1'b0);
    check1("midrst_mem_we", mem_we, 1'b0);
    check32("midrst_mem_sel", {28'h0, mem_sel}, 32'h0);
    check32("midrst_mem_addr", mem_addr, 32'h0);
    check32("midrst_mem_wdata", mem_wdata, 32'h0);
    check32("midrst_if_rdata", if_rdata, 32'h0);
    check32("midrst_dm_rdata", dm_rdata, 32'h0);
    check1("midrst_stall", stall_req, 1'b0);
    rst = 1'b0;
    seen_ack = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (if_ack || dm_ack) seen_ack = 1;
    end
    check1("midrst_no_late_ack", seen_ack, 1'b0);
    last_if_rdata = '0;
    last_dm_rdata = '0;
    run_vec(post_rst, 6);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: memory never answers
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0300;
    wait_n = 100000; rd_val = 32'h1234_5678;
    cyc = 0; ce_cnt = 0; got = 0;
    while (!got && cyc < 300) begin
      tick();
      cyc++;
      if (mem_ce) ce_cnt++;
      if (if_ack || dm_ack) got = 1;
    end
    check_int("wd_busy_cycles", ce_cnt, TIMEOUT);
    check1("wd_bus_err", bus_err, 1'b1);
    check1("wd_dm_ack", dm_ack, 1'b1);
    check32("wd_dm_rdata", dm_rdata, 32'h0);
    check1("wd_mem_ce", mem_ce, 1'b0);
    dm_req = 1'b0;
    tick();
    check1("wd_bus_err_pulse", bus_err, 1'b0);
    check1("wd_ack_pulse", dm_ack, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
